// File: rtl/reg_file_sb.sv
// Register file with a pending-producer scoreboard.
// Reads are combinational and bypass same-cycle writes; the youngest write port wins.
// After reset or a soft clear, an INIT sweep zeroes registers 1..NUM_REGS-1 before the file reports ready.
module reg_file_sb #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr,
    input  logic                     clr_req,
    output logic                     ready
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_WR-1:0]   wr_ok;

    assign ready = (state_q == ST_READY);

    // A user write is accepted only when ready and not aimed at the hardwired zero register.
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_ok
        assign wr_ok[gi] = wr_en[gi] && ready && (wr_addr[gi*AW +: AW] != '0);
    end

    // Next-state logic: INIT sweeps cnt from 1 up to NUM_REGS-1, READY waits for a soft clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == AW'(NUM_REGS - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = AW'(1);
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d = ST_INIT;
                    cnt_d   = AW'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = AW'(1);
            end
        endcase
    end

    // Scoreboard: the soft-clear edge and INIT keep everything idle; otherwise writes clear and issues set, with set winning.
    always_comb begin
        busy_d = busy_q;
        if (state_q == ST_READY && !clr_req) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_ok[i]) begin
                    busy_d[wr_addr[i*AW +: AW]] = 1'b0;
                end
            end
            if (issue_en && issue_addr != '0) begin
                busy_d[issue_addr] = 1'b1;
            end
        end else begin
            busy_d = '0;
        end
    end

    // Control state with asynchronous active-low reset; reset also restarts the sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= AW'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage update: the sweep zeroes one register per cycle, else writes apply in port order so the younger port lands last.
    always_comb begin
        regs_d = regs_q;
        if (state_q == ST_INIT) begin
            regs_d[cnt_q] = '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_ok[i]) begin
                    regs_d[wr_addr[i*AW +: AW]] = wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
        regs_d[0] = '0;
    end

    // Storage array carries no reset; the INIT sweep gives it defined contents.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read ports: bypass same-cycle writes, and a bypassed source is never reported busy.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              byp;
        logic              active;

        assign addr   = rd_addr[gi*AW +: AW];
        assign active = rst && ready && rd_en[gi] && (addr != '0);

        // Pick the stored value, overridden by matching writes from oldest to youngest port.
        always_comb begin
            data = regs_q[addr];
            byp  = 1'b0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_ok[i] && wr_addr[i*AW +: AW] == addr) begin
                    data = wr_data[i*DATA_W +: DATA_W];
                    byp  = 1'b1;
                end
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = active ? data : '0;
        assign rd_busy[gi]                  = active && !byp && busy_q[addr];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model of the register file and scoreboard.
module tb_reg_file_sb;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NWR-1:0]     wr_en;
    logic [NWR*AW-1:0]  wr_addr;
    logic [NWR*DW-1:0]  wr_data;
    logic [NRD-1:0]     rd_en;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*DW-1:0]  rd_data;
    logic [NRD-1:0]     rd_busy;
    logic               issue_en;
    logic [AW-1:0]      issue_addr;
    logic               clr_req;
    logic               ready;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Behavioural model: contents, pending flags, and how many sweep edges remain before ready.
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    bit            m_ready     = 1'b0;
    int            m_init_left = NR - 1;

    reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .clr_req    (clr_req),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
        issue_en = 1'b0; issue_addr = '0; clr_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic do_issue(input logic [AW-1:0] a);
        issue_en = 1'b1;
        issue_addr = a;
    endtask

    function automatic logic [DW-1:0] get_rd(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    // Counts falling edges with ready low, starting from the current point; bounded.
    task automatic count_not_ready(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (ready || n >= 100) break;
            n++;
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_init_left = NR - 1;
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Compare process: on each falling edge check outputs against the model, then advance the model over the coming rising edge.
    initial begin : cmp
        logic [AW-1:0] ea;
        logic [AW-1:0] wa;
        logic [DW-1:0] ed;
        logic          eb;
        model_reset();
        forever begin
            @(negedge clk);
            for (int j = 0; j < NRD; j++) begin
                ea = rd_addr[j*AW +: AW];
                ed = '0;
                eb = 1'b0;
                if (rst && m_ready && rd_en[j] && ea != 0) begin
                    ed = m_regs[ea];
                    eb = m_busy[ea];
                    for (int i = 0; i < NWR; i++) begin
                        if (wr_en[i] && wr_addr[i*AW +: AW] == ea) begin
                            ed = wr_data[i*DW +: DW];
                            eb = 1'b0;
                        end
                    end
                end
                check($sformatf("model_rd_data%0d", j), get_rd(j), ed);
                check($sformatf("model_rd_busy%0d", j), DW'(rd_busy[j]), DW'(eb));
            end
            check("model_ready", DW'(ready), DW'(rst && m_ready));

            if (!rst) begin
                model_reset();
            end else if (!m_ready) begin
                m_init_left--;
                if (m_init_left == 0) m_ready = 1'b1;
            end else if (clr_req) begin
                model_reset();
            end else begin
                for (int i = 0; i < NWR; i++) begin
                    wa = wr_addr[i*AW +: AW];
                    if (wr_en[i] && wa != 0) begin
                        m_regs[wa] = wr_data[i*DW +: DW];
                        m_busy[wa] = 1'b0;
                    end
                end
                if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin : drv
        int n;
        idle();
        rst = 1'b0;
        repeat (3) tick();

        // Reset holds outputs low even with a read enabled.
        set_rd(0, 5);
        @(negedge clk);
        check("reset_ready", DW'(ready), 0);
        check("reset_rd_data", get_rd(0), 0);
        $display("txn reset hold: ready=%0d rd_data0=0x%0h", ready, get_rd(0));
        tick();

        // Release reset and measure the sweep length.
        idle();
        rst = 1'b1;
        count_not_ready(n);
        check("init_len", n, 31);
        $display("txn reset release: ready low for %0d cycles", n);
        tick();

        // Every register reads zero after the sweep.
        for (int a = 1; a < NR; a++) begin
            idle();
            set_rd(0, AW'(a));
            set_rd(1, AW'(NR - a));
            @(negedge clk);
            check($sformatf("sweep_r%0d", a), get_rd(0), 0);
            check($sformatf("sweep_r%0d", NR - a), get_rd(1), 0);
            tick();
        end
        $display("txn sweep readback of r1..r31 done");

        // Same-cycle double write: younger port wins, in bypass and after.
        idle();
        set_wr(0, 5, 32'h1111_1111);
        set_wr(1, 5, 32'h2222_2222);
        set_rd(0, 5);
        @(negedge clk);
        check("dual_write_bypass", get_rd(0), 32'h2222_2222);
        $display("txn dual write r5: bypass=0x%0h", get_rd(0));
        tick();
        idle();
        set_rd(0, 5);
        @(negedge clk);
        check("dual_write_stored", get_rd(0), 32'h2222_2222);
        $display("txn read r5: 0x%0h", get_rd(0));
        tick();

        // Register 0 ignores writes and issues.
        idle();
        set_wr(0, 0, 32'hDEAD_BEEF);
        do_issue(0);
        set_rd(0, 0);
        set_rd(1, 0);
        @(negedge clk);
        check("r0_bypass", get_rd(0), 0);
        check("r0_busy", DW'(rd_busy[1]), 0);
        tick();
        idle();
        set_rd(0, 0);
        @(negedge clk);
        check("r0_stored", get_rd(0), 0);
        check("r0_busy_after", DW'(rd_busy[0]), 0);
        $display("txn write r0: read=0x%0h busy=%0d", get_rd(0), rd_busy[0]);
        tick();

        // Scoreboard: issue, then read busy, then a clearing write with bypass.
        idle();
        do_issue(7);
        @(negedge clk);
        tick();
        idle();
        set_rd(0, 7);
        @(negedge clk);
        check("issue_r7_busy", DW'(rd_busy[0]), 1);
        $display("txn issue r7: busy=%0d", rd_busy[0]);
        tick();
        idle();
        set_rd(0, 7);
        set_wr(0, 7, 32'hA5);
        @(negedge clk);
        check("write_r7_busy", DW'(rd_busy[0]), 0);
        check("write_r7_data", get_rd(0), 32'hA5);
        $display("txn write r7: data=0x%0h busy=%0d", get_rd(0), rd_busy[0]);
        tick();
        idle();
        set_rd(0, 7);
        @(negedge clk);
        check("r7_cleared", DW'(rd_busy[0]), 0);
        tick();
        idle();
        do_issue(7);
        set_wr(1, 7, 32'h5A);
        @(negedge clk);
        tick();
        idle();
        set_rd(0, 7);
        @(negedge clk);
        check("issue_and_write_busy", DW'(rd_busy[0]), 1);
        check("issue_and_write_data", get_rd(0), 32'h5A);
        $display("txn issue+write r7: data=0x%0h busy=%0d", get_rd(0), rd_busy[0]);
        tick();

        // Soft clear with a stored value and a pending register; traffic during the sweep is dropped.
        idle();
        set_wr(0, 3, 32'h1234);
        do_issue(9);
        @(negedge clk);
        tick();
        idle();
        set_rd(0, 3);
        set_rd(1, 9);
        clr_req = 1'b1;
        @(negedge clk);
        check("pre_clr_r3", get_rd(0), 32'h1234);
        check("pre_clr_r9_busy", DW'(rd_busy[1]), 1);
        tick();
        idle();
        n = 0;
        while (!ready && n < 100) begin
            set_wr(0, 3, 32'hFFFF);
            do_issue(9);
            set_rd(0, 3);
            set_rd(1, 9);
            @(negedge clk);
            tick();
            idle();
            n++;
        end
        check("clr_len", n, 31);
        set_rd(0, 3);
        set_rd(1, 9);
        @(negedge clk);
        check("post_clr_r3", get_rd(0), 0);
        check("post_clr_r9_busy", DW'(rd_busy[1]), 0);
        $display("txn soft clear: %0d cycles, r3=0x%0h r9 busy=%0d", n, get_rd(0), rd_busy[1]);
        tick();

        // Reset mid-operation acts immediately, between clock edges.
        idle();
        set_wr(0, 4, 32'h77);
        do_issue(6);
        @(negedge clk);
        tick();
        idle();
        set_rd(0, 4);
        set_rd(1, 6);
        @(negedge clk);
        check("pre_rst_r4", get_rd(0), 32'h77);
        check("pre_rst_r6_busy", DW'(rd_busy[1]), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ready", DW'(ready), 0);
        check("async_rst_data", get_rd(0), 0);
        check("async_rst_busy", DW'(rd_busy[1]), 0);
        $display("txn async reset: ready=%0d data=0x%0h busy=%0d", ready, get_rd(0), rd_busy[1]);
        tick();
        tick();
        rst = 1'b1;

        // Reset again once cnt has reached 10, then expect a full sweep.
        repeat (9) tick();
        check("mid_sweep_not_ready", DW'(ready), 0);
        rst = 1'b0;
        #1;
        check("mid_sweep_rst_ready", DW'(ready), 0);
        check("mid_sweep_rst_data", get_rd(0), 0);
        tick();
        rst = 1'b1;
        count_not_ready(n);
        check("mid_sweep_restart_len", n, 31);
        $display("txn reset mid-sweep: restart ran %0d cycles", n);
        tick();
        idle();
        set_rd(0, 4);
        set_rd(1, 6);
        @(negedge clk);
        check("post_rst_r4", get_rd(0), 0);
        check("post_rst_r6_busy", DW'(rd_busy[1]), 0);
        tick();

        // Randomized traffic, including occasional soft clears and resets.
        for (int c = 0; c < 4000; c++) begin
            idle();
            for (int p = 0; p < NWR; p++) if ($urandom_range(0, 1) == 1) set_wr(p, rand_addr(), $urandom());
            for (int p = 0; p < NRD; p++) if ($urandom_range(0, 3) != 0) set_rd(p, rand_addr());
            if ($urandom_range(0, 2) == 0) do_issue(rand_addr());
            clr_req = ($urandom_range(0, 299) == 0);
            rst = ($urandom_range(0, 599) != 0);
            @(negedge clk);
            tick();
        end
        $display("txn random traffic: 4000 cycles");

        idle();
        rst = 1'b1;
        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter NUM_REGS, default 32: number of architectural registers; power of two, at least 4; AW = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2: number of read ports, 1 to 4.
REQ-004 Parameter NUM_WR, default 2: number of write ports, 1 to 2; higher index = younger.
REQ-005 clk  in  1: the single clock; all state updates on the rising edge.
REQ-006 rst  in  1: asynchronous, active-low reset.
REQ-007 wr_en  in  NUM_WR: per-port write enable.
REQ-008 wr_addr  in  NUM_WR*AW: per-port destination index; port i occupies slice [i*AW +: AW].
REQ-009 wr_data  in  NUM_WR*DATA_W: per-port write data.
REQ-010 rd_en  in  NUM_RD: per-port read enable.
REQ-011 rd_addr  in  NUM_RD*AW: per-port source index.
REQ-012 rd_data  out  NUM_RD*DATA_W: per-port read data, combinational.
REQ-013 rd_busy  out  NUM_RD: per-port flag; 1 = the source has a pending, unwritten producer.
REQ-014 issue_en  in  1: marks issue_addr as pending.
REQ-015 issue_addr  in  AW: register to mark pending.
REQ-016 clr_req  in  1: single-cycle pulse that requests a full soft clear.
REQ-017 ready  out  1: 1 = the file is initialised and accepts writes, issues and reads.

Function
REQ-018 Register 0 SHALL always read as 0; writes to it and issues to it SHALL be ignored.
REQ-019 A write SHALL take effect on the rising edge when wr_en[i]=1, ready=1 and wr_addr!=0.
REQ-020 If both write ports target the same address in one cycle, port NUM_WR-1 SHALL win.
REQ-021 A read SHALL return 0 when rd_en=0, ready=0, rst=0 or rd_addr=0.
REQ-022 Otherwise, a read SHALL return the same-cycle write data (bypass) when a write port targets rd_addr with wr_en=1; the REQ-020 priority applies; the stored value is returned otherwise.
REQ-023 Scoreboard: the block SHALL keep one busy bit per register, all cleared by reset.
REQ-024 When issue_en=1 and ready=1, busy[issue_addr] SHALL be set on the next edge.
REQ-025 An accepted write SHALL clear busy[wr_addr] on the next edge.
REQ-026 If an issue and a write target the same register in one cycle, set SHALL win and busy SHALL stay 1.
REQ-027 rd_busy[j] SHALL equal busy[rd_addr[j]] AND rd_en[j] AND ready.
REQ-028 rd_busy[j] SHALL be 0 for address 0 and 0 when a same-cycle write to rd_addr[j] is present (bypass covers it).
REQ-029 FSM states: INIT, READY.
REQ-030 INIT SHALL hold a counter cnt starting at 1, write 0 to register cnt each cycle, and increment cnt.
REQ-031 INIT SHALL go to READY on the cycle after cnt = NUM_REGS-1 is written; that is NUM_REGS-1 cycles in INIT.
REQ-032 READY SHALL return to INIT with cnt=1 when clr_req=1.
REQ-033 On that soft clear, all busy bits SHALL clear on the same edge.
REQ-034 ready SHALL be 1 only in READY.
REQ-035 In INIT, user writes, issues and clr_req SHALL be ignored.

Reset
REQ-036 While rst=0, the block SHALL hold: state=INIT, cnt=1, busy=0, ready=0, rd_data=0, rd_busy=0, all asynchronously.
REQ-037 After rst deasserts, the INIT sweep SHALL run; register contents SHALL be 0 when ready rises.
REQ-038 Reset asserted mid-INIT or mid-operation SHALL abort immediately and restart the sweep from cnt=1.

Verification
REQ-039 Reset release with defaults -> ready=0 for exactly 31 cycles, then 1; every register reads 0.
REQ-040 Same-cycle writes: port0 writes r5=0x11111111 and port1 writes r5=0x22222222 -> same-cycle read of r5 returns 0x22222222; the next cycle also returns 0x22222222.
REQ-041 Write r0=0xDEADBEEF -> reads of r0 return 0; rd_busy=0.
REQ-042 Scoreboard: issue r7, then read r7 -> rd_busy=1; write r7=0xA5 -> rd_busy=0 with data 0xA5 in the same cycle; simultaneous issue and write of r7 -> busy stays 1 afterward.
REQ-043 Soft clear: after r3=0x1234 and busy r9, pulse clr_req -> ready=0 for 31 cycles; r3 reads 0 and r9 is not busy afterward; writes issued during the sweep are lost.
REQ-044 Reset mid-sweep at cnt=10 -> outputs go to reset values immediately; after release a full 31-cycle sweep runs.
